mips_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 16-bit MIPS-subset ALU datapath.
- Accepts one 32-bit instruction per valid/ready handshake and reads rs/rt from a writable 32x16 register file.
- Executes the instruction, writes the result back, and drives the 7-segment display code of the low result nibble with a one-cycle out_valid pulse.
- Replaces the constant-ROM operand source with a real, writable register file, so dependent instruction sequences can run.

---
 rtl/mips_seq_ctrl_pkg.sv | 52 +++++
 rtl/mips_seq_ctrl_if.sv | 15 +
 rtl/mips_seq_ctrl_regfile.sv | 32 +++
 rtl/mips_seq_ctrl.sv | 107 ++++++++++
 tb/tb_mips_seq_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_seq_ctrl_pkg.sv
// Shared types, constants and helpers for the multi-cycle MIPS-subset sequencer.
// Holds funct codes, FSM state encoding, register reset image and 7-seg decode.
package mips_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned DW   = 16;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    function automatic logic [DW-1:0] reg_init(input logic [4:0] idx);
        case (idx)
            5'd13:   reg_init = 16'd12;
            5'd14:   reg_init = 16'd38;
            5'd17:   reg_init = 16'd27;
            5'd18:   reg_init = 16'd150;
            5'd27:   reg_init = 16'd379;
            5'd29:   reg_init = 16'd142;
            5'd31:   reg_init = 16'd1508;
            default: reg_init = '0;
        endcase
    endfunction

    // Segment order is {a,b,c,d,e,f,g}, active high.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1111110;
            4'h1: seg7 = 7'b0110000;
            4'h2: seg7 = 7'b1101101;
            4'h3: seg7 = 7'b1111001;
            4'h4: seg7 = 7'b0110011;
            4'h5: seg7 = 7'b1011011;
            4'h6: seg7 = 7'b1011111;
            4'h7: seg7 = 7'b1110000;
            4'h8: seg7 = 7'b1111111;
            4'h9: seg7 = 7'b1111011;
            4'hA: seg7 = 7'b1110111;
            4'hB: seg7 = 7'b0011111;
            4'hC: seg7 = 7'b1001110;
            4'hD: seg7 = 7'b0111101;
            4'hE: seg7 = 7'b1001111;
            default: seg7 = 7'b1000111;
        endcase
    endfunction

endpackage

// File: rtl/mips_seq_ctrl_if.sv
// Instruction handshake and result bus of the MIPS sequencer.
interface mips_seq_ctrl_if;
    logic        in_valid;
    logic [31:0] instruction;
    logic        in_ready;
    logic        out_valid;
    logic [6:0]  out;
    logic        out_carry;
    logic        out_illegal;

    modport master (output in_valid, instruction,
                    input  in_ready, out_valid, out, out_carry, out_illegal);
    modport slave  (input  in_valid, instruction,
                    output in_ready, out_valid, out, out_carry, out_illegal);
endinterface

// File: rtl/mips_seq_ctrl_regfile.sv
// 32x16 register file: two combinational reads, one synchronous write, r0 fixed at 0.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [DW-1:0]           rdata_a,
    output logic [DW-1:0]           rdata_b,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DW-1:0]           wdata
);
    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= DW'(reg_init(5'(i)));
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/mips_seq_ctrl.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) driving the ALU and register file.
// Result fields are registered at the WB edge, so out_valid appears the cycle after it.
module mips_seq_ctrl
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mips_seq_ctrl_if.slave bus
);
    state_t          state, state_nx;
    logic [31:0]     instr_q;
    logic [DW-1:0]   op_a, op_b, rd_a, rd_b;
    logic [DW:0]     result_q, alu_res;
    logic            illegal_q, alu_illegal;
    logic            rf_we;
    logic [4:0]      waddr;
    logic            out_valid_q, out_carry_q, out_illegal_q;
    logic [6:0]      out_q;

    mips_regfile #(.NREG(NREG), .DW(DW)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (instr_q[25:21]),
        .raddr_b (instr_q[20:16]),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .we      (rf_we),
        .waddr   (waddr),
        .wdata   (result_q[DW-1:0])
    );

    assign waddr = instr_q[29] ? instr_q[20:16] : instr_q[15:11];

    always_comb begin
        state_nx = state;
        rf_we    = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) state_nx = READ;
            READ: state_nx = EXEC;
            EXEC: state_nx = WB;
            WB: begin
                state_nx = IDLE;
                rf_we    = !illegal_q;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        if (instr_q[29]) begin
            alu_res = {1'b0, op_a} + {1'b0, instr_q[15:0]};
        end else begin
            case (instr_q[5:0])
                F_ADD: alu_res = {1'b0, op_a} + {1'b0, op_b};
                F_AND: alu_res = {1'b0, op_a & op_b};
                F_OR:  alu_res = {1'b0, op_a | op_b};
                F_NOR: alu_res = ~{1'b0, op_a | op_b};
                F_SLL: alu_res = {1'b0, op_b} << instr_q[10:6];
                F_SRL: alu_res = {1'b0, op_b} >> instr_q[10:6];
                default: alu_illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            instr_q       <= '0;
            op_a          <= '0;
            op_b          <= '0;
            result_q      <= '0;
            illegal_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_q         <= '0;
            out_carry_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state       <= state_nx;
            out_valid_q <= (state == WB);
            case (state)
                IDLE: if (bus.in_valid) instr_q <= bus.instruction;
                READ: begin
                    op_a <= rd_a;
                    op_b <= rd_b;
                end
                EXEC: begin
                    result_q  <= alu_res;
                    illegal_q <= alu_illegal;
                end
                WB: begin
                    out_q         <= seg7(result_q[3:0]);
                    out_carry_q   <= result_q[DW];
                    out_illegal_q <= illegal_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out         = out_q;
    assign bus.out_carry   = out_carry_q;
    assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed scoreboard bench for mips_seq_ctrl: a reference model predicts each result at handshake.
module tb_mips_seq_ctrl;

    typedef struct {
        logic [6:0]  seg;
        logic        carry;
        logic        illegal;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    exp_t sb[$];
    logic [15:0] mr [32];
    logic [6:0]  seg_tbl [16];
    int unsigned acc_cyc [4];

    mips_seq_ctrl_if bus ();

    mips_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        foreach (mr[i]) mr[i] = '0;
        mr[13] = 16'd12;  mr[14] = 16'd38;   mr[17] = 16'd27;  mr[18] = 16'd150;
        mr[27] = 16'd379; mr[29] = 16'd142;  mr[31] = 16'd1508;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] itype(input int rs, input int rt, input logic [15:0] imm);
        return {6'b001000, 5'(rs), 5'(rt), imm};
    endfunction

    // Predict result from the model, apply writeback to the model, queue expected fields.
    task automatic predict(input logic [31:0] ins, input int unsigned exp_cyc);
        logic [16:0] a, b, r;
        logic        ill;
        logic [4:0]  dst;
        exp_t        e;
        a = {1'b0, mr[ins[25:21]]};
        b = {1'b0, mr[ins[20:16]]};
        r = '0;
        ill = 1'b0;
        if (ins[29]) begin
            r = a + {1'b0, ins[15:0]};
            dst = ins[20:16];
        end else begin
            dst = ins[15:11];
            case (ins[5:0])
                6'b100000: r = a + b;
                6'b100100: r = a & b;
                6'b100101: r = a | b;
                6'b100111: r = ~(a | b);
                6'b000000: r = b << ins[10:6];
                6'b000010: r = b >> ins[10:6];
                default:   ill = 1'b1;
            endcase
        end
        if (!ill && dst != 5'd0) mr[dst] = r[15:0];
        e.seg = seg_tbl[r[3:0]];
        e.carry = r[16];
        e.illegal = ill;
        e.cyc = exp_cyc;
        sb.push_back(e);
    endtask

    // Present an instruction, wait (bounded) for in_ready, return just after the accepting edge.
    task automatic send(input logic [31:0] ins, input bit push, output int unsigned acc);
        int unsigned n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instruction = ins;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
        acc = cyc + 1;
        if (push) predict(ins, acc + 3);
        @(negedge clk);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("out", {25'b0, bus.out}, {25'b0, e.seg});
                chk("out_carry", {31'b0, bus.out_carry}, {31'b0, e.carry});
                chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, e.illegal});
            end
        end
    end

    initial begin
        int unsigned acc;
        seg_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        model_reset();
        bus.in_valid = 1'b0;
        bus.instruction = '0;
        #12;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out", {25'b0, bus.out}, 32'd0);
        chk("rst_carry", {31'b0, bus.out_carry}, 32'd0);
        rst_n = 1'b1;

        send(rtype(13, 14, 1, 0, 6'b100000), 1'b1, acc);
        bus.in_valid = 1'b0;
        drain();
        chk("r1_add", {16'b0, dut.u_rf.regs[1]}, 32'd50);

        send(rtype(1, 1, 2, 0, 6'b100000), 1'b1, acc);
        send(itype(31, 3, 16'hFFFF), 1'b1, acc);
        send(rtype(0, 29, 5, 4, 6'b000000), 1'b1, acc);
        send(rtype(0, 5, 6, 8, 6'b000010), 1'b1, acc);
        send(rtype(17, 18, 9, 0, 6'b100100), 1'b1, acc);
        send(rtype(17, 18, 10, 0, 6'b100101), 1'b1, acc);
        send(rtype(17, 18, 11, 0, 6'b100111), 1'b1, acc);
        send(rtype(13, 14, 7, 0, 6'b111111), 1'b1, acc);
        send(rtype(13, 14, 0, 0, 6'b100000), 1'b1, acc);
        bus.in_valid = 1'b0;
        drain();
        chk("r2_add", {16'b0, dut.u_rf.regs[2]}, 32'd100);
        chk("r3_addi", {16'b0, dut.u_rf.regs[3]}, 32'h05E3);
        chk("r5_sll", {16'b0, dut.u_rf.regs[5]}, 32'h08E0);
        chk("r6_srl", {16'b0, dut.u_rf.regs[6]}, 32'h0008);
        chk("r11_nor", {16'b0, dut.u_rf.regs[11]}, 32'hFF60);
        chk("r7_illegal", {16'b0, dut.u_rf.regs[7]}, 32'd0);
        chk("r0_fixed", {16'b0, dut.u_rf.regs[0]}, 32'd0);

        // in_valid stays high across all four; acceptance must be every 4th cycle.
        send(rtype(27, 13, 20, 0, 6'b100000), 1'b1, acc_cyc[0]);
        send(rtype(20, 20, 21, 0, 6'b100000), 1'b1, acc_cyc[1]);
        send(itype(21, 22, 16'h1234), 1'b1, acc_cyc[2]);
        send(rtype(22, 2, 23, 0, 6'b100101), 1'b1, acc_cyc[3]);
        bus.in_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd4);
        drain();
        chk("r23_b2b", {16'b0, dut.u_rf.regs[23]}, {16'b0, mr[23]});

        // Abort mid-EXEC: no result, no writeback, registers back to their reset image.
        send(rtype(13, 14, 9, 0, 6'b100000), 1'b0, acc);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        chk("abort_r9", {16'b0, dut.u_rf.regs[9]}, 32'd0);
        chk("abort_r13", {16'b0, dut.u_rf.regs[13]}, 32'd12);
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);

        send(rtype(13, 17, 12, 0, 6'b100000), 1'b1, acc);
        bus.in_valid = 1'b0;
        drain();
        chk("post_reset_r12", {16'b0, dut.u_rf.regs[12]}, 32'd39);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
